// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads 16-bit words from instruction
// memory one at a time and hands complete (optionally two-word) instructions to decode.
module fetch_queue #(
    parameter int               ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [5:0]       EXT_OPCODE = 6'h00
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ins_ready,
    output logic [15:0]       ins,
    output logic [15:0]       ext,
    output logic              ins_en,
    output logic [ADDR_W-1:0] ins_pc
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       pc;
    logic [1:0][15:0]        q_word;
    logic [1:0][ADDR_W-1:0]  q_addr;
    logic [1:0]              occ;

    logic                    head_ext;
    logic                    head_complete;
    logic                    pop;
    logic [1:0]              pop_cnt;
    logic                    push;
    logic [1:0][15:0]        nq_word;
    logic [1:0][ADDR_W-1:0]  nq_addr;
    logic [1:0]              n_occ;

    // An extension-opcode head is only issuable once its trailing word is queued.
    assign head_ext      = (q_word[0][15:10] == EXT_OPCODE);
    assign head_complete = (occ != 2'd0) && (!head_ext || occ == 2'd2);
    assign pop           = ins_ready && head_complete && !redirect;
    assign pop_cnt       = pop ? (head_ext ? 2'd2 : 2'd1) : 2'd0;
    assign push          = (state == WAIT) && imem_ack && !redirect;

    always_comb begin
        nq_word = q_word;
        nq_addr = q_addr;
        n_occ   = occ - pop_cnt;
        if (pop_cnt == 2'd1) begin
            nq_word[0] = q_word[1];
            nq_addr[0] = q_addr[1];
        end
        // A push only happens when a slot is free, so the post-pop occupancy is 0 or 1.
        if (push) begin
            nq_word[n_occ[0]] = imem_rdata;
            nq_addr[n_occ[0]] = pc;
            n_occ             = n_occ + 2'd1;
        end
        if (redirect)
            n_occ = 2'd0;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            occ       <= 2'd0;
            q_word    <= '0;
            q_addr    <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ins       <= 16'h0000;
            ext       <= 16'h0000;
            ins_en    <= 1'b0;
            ins_pc    <= '0;
        end else begin
            q_word <= nq_word;
            q_addr <= nq_addr;
            occ    <= n_occ;
            ins_en <= pop;
            if (pop) begin
                ins    <= q_word[0];
                ext    <= head_ext ? q_word[1] : 16'h0000;
                ins_pc <= q_addr[0];
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (occ != 2'd2) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        imem_req <= 1'b0;
                        pc       <= redirect_pc;
                        state    <= imem_ack ? IDLE : DISCARD;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        pc       <= pc + 1'b1;
                        state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect)
                        pc <= redirect_pc;
                    // Memory still owes one response; swallow it before fetching again.
                    if (imem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a behavioural memory responder plus a stream-level model that
// parses memory from the current start address and predicts every delivered instruction.
module tb_fetch_queue;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ins_ready;
    logic [15:0] ins;
    logic [15:0] ext;
    logic        ins_en;
    logic [15:0] ins_pc;

    fetch_queue #(.ADDR_W(16), .RESET_PC(16'h0000), .EXT_OPCODE(6'h00)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_ready(ins_ready), .ins(ins), .ext(ext), .ins_en(ins_en), .ins_pc(ins_pc)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    logic [15:0] mem [0:65535];

    int          total, bad;
    logic [15:0] exp_pc, exp_req;
    int          reqs, consumed;
    bit          rsp_busy;
    int          rsp_cnt;
    logic [15:0] rsp_addr;
    int          ack_delay;
    bit          rand_delay;
    bit          new_req, got_ins;
    logic [15:0] new_req_addr;
    int          req_cnt, ins_cnt;

    typedef struct {
        logic [15:0] start, w0, w1, exp_ins, exp_ext, exp_pc, exp_next;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample #1 after the edge, check, then run the memory responder.
    task automatic step(input bit rst, input bit rdy, input bit rd, input logic [15:0] rd_pc);
        logic [15:0] w;
        bit          ex;
        int          d;
        cpu_rst = rst; ins_ready = rdy; redirect = rd; redirect_pc = rd_pc;
        @(posedge cpu_clk); #1;
        new_req = 1'b0; got_ins = 1'b0;
        if (rst || rd) begin
            if (rst) chk("ins_en_in_reset", ins_en, 0);
            else     chk("ins_en_after_redirect", ins_en, 0);
            exp_pc   = rst ? 16'h0000 : rd_pc;
            exp_req  = exp_pc;
            reqs     = 0;
            consumed = 0;
        end else if (ins_en) begin
            w  = mem[exp_pc];
            ex = (w[15:10] == 6'h00);
            chk("ins_pc", ins_pc, exp_pc);
            chk("ins", ins, w);
            chk("ext", ext, ex ? mem[exp_pc + 16'd1] : 16'h0000);
            consumed += ex ? 2 : 1;
            exp_pc   += ex ? 16'd2 : 16'd1;
            got_ins   = 1'b1;
            ins_cnt++;
        end
        if (imem_ack) begin
            imem_ack = 1'b0;
            rsp_busy = 1'b0;
        end else if (rsp_busy) begin
            if (imem_req) chk("imem_addr_stable", imem_addr, rsp_addr);
            if (rsp_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[rsp_addr];
            end else begin
                rsp_cnt--;
            end
        end
        if (!rsp_busy && imem_req && !rst) begin
            new_req = 1'b1; new_req_addr = imem_addr; req_cnt++;
            chk("imem_addr_seq", imem_addr, exp_req);
            exp_req++;
            reqs++;
            chk("space_rule", (reqs - consumed) <= 2, 1);
            d        = rand_delay ? int'($urandom_range(1, 3)) : ack_delay;
            rsp_busy = 1'b1;
            rsp_cnt  = d - 1;
            rsp_addr = imem_addr;
        end
    endtask

    task automatic run_until_ins(input bit rdy, input int lim);
        int n = 0;
        do begin step(0, rdy, 0, 16'h0); n++; end while (!got_ins && n < lim);
        if (!got_ins) chk("ins_en_timeout", 0, 1);
    endtask

    task automatic run_until_req(input bit rdy, input int lim);
        int n = 0;
        do begin step(0, rdy, 0, 16'h0); n++; end while (!new_req && n < lim);
        if (!new_req) chk("imem_req_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w, a;
        int          rc0, ic0, n;
        bit          rd;
        total = 0; bad = 0; reqs = 0; consumed = 0; req_cnt = 0; ins_cnt = 0;
        exp_pc = 0; exp_req = 0; rsp_busy = 0; rsp_cnt = 0; rsp_addr = 0;
        ack_delay = 1; rand_delay = 0;
        cpu_rst = 1; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; ins_ready = 0;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:10] = 6'h00;
            mem[i] = w;
        end
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 16; i++) begin
            mem[16'h0040 + i] = 16'h4000 + 16'(i);
            mem[16'h0100 + i] = 16'h2000 + 16'(i);
            mem[16'h0200 + i] = 16'h3000 + 16'(i);
        end
        tbl[0] = '{16'h0080, 16'h1234, 16'h5678, 16'h1234, 16'h0000, 16'h0080, 16'h0081};
        tbl[1] = '{16'h0000, 16'h0005, 16'hBEEF, 16'h0005, 16'hBEEF, 16'h0000, 16'h0002};
        tbl[2] = '{16'hFFFF, 16'h0007, 16'hCAFE, 16'h0007, 16'hCAFE, 16'hFFFF, 16'h0001};
        tbl[3] = '{16'hFFFF, 16'h8001, 16'h9002, 16'h8001, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[4] = '{16'h0090, 16'hFC00, 16'h0000, 16'hFC00, 16'h0000, 16'h0090, 16'h0091};

        // Reset values
        step(1, 0, 0, 16'h0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_ins", ins, 0);
        chk("rst_ext", ext, 0);
        chk("rst_ins_pc", ins_pc, 0);
        step(1, 0, 0, 16'h0);

        // Sequential stream from reset
        run_until_ins(1, 20);
        chk("first_ins", ins, 16'h1000);
        chk("first_pc", ins_pc, 16'h0000);
        run_until_ins(1, 20);
        chk("second_ins", ins, 16'h1001);
        chk("second_pc", ins_pc, 16'h0001);
        repeat (10) step(0, 1, 0, 16'h0);

        // Table-driven start addresses, extension pairing and PC wrap
        foreach (tbl[k]) begin
            a = tbl[k].start + 16'd1;
            mem[tbl[k].start] = tbl[k].w0;
            mem[a]            = tbl[k].w1;
            step(0, 1, 1, tbl[k].start);
            run_until_ins(1, 40);
            chk($sformatf("vec%0d_ins", k), ins, tbl[k].exp_ins);
            chk($sformatf("vec%0d_ext", k), ext, tbl[k].exp_ext);
            chk($sformatf("vec%0d_pc", k), ins_pc, tbl[k].exp_pc);
            run_until_ins(1, 40);
            chk($sformatf("vec%0d_next_pc", k), ins_pc, tbl[k].exp_next);
        end
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);

        // Back-pressure: queue fills, fetching stops, then drains in order
        step(0, 0, 1, 16'h0000);
        rc0 = req_cnt; ic0 = ins_cnt;
        repeat (12) step(0, 0, 0, 16'h0);
        chk("bp_req_count", (req_cnt - rc0) <= 2, 1);
        chk("bp_req_low", imem_req, 0);
        chk("bp_no_ins", ins_cnt - ic0, 0);
        run_until_ins(1, 10);
        chk("bp_drain0_pc", ins_pc, 16'h0000);
        run_until_ins(1, 10);
        chk("bp_drain1_pc", ins_pc, 16'h0001);
        chk("bp_drain1_ins", ins, 16'h1001);

        // Redirect while waiting on addr 3, its ack arriving three cycles later
        ack_delay = 3;
        step(0, 1, 1, 16'h0000);
        n = 0;
        do begin step(0, 1, 0, 16'h0); n++; end while (!(new_req && new_req_addr == 16'h0003) && n < 60);
        chk("saw_req_addr3", new_req && new_req_addr == 16'h0003, 1);
        step(0, 1, 1, 16'h0040);
        run_until_req(1, 20);
        chk("redir_req_addr", new_req_addr, 16'h0040);
        run_until_ins(1, 30);
        chk("redir_ins_pc", ins_pc, 16'h0040);
        chk("redir_ins", ins, 16'h4000);

        // Redirect coinciding with an ack and a pending pop
        ack_delay = 2;
        step(0, 0, 1, 16'h0100);
        repeat (12) step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        n = 0;
        while (!imem_ack && n < 20) begin step(0, 0, 0, 16'h0); n++; end
        chk("coincide_ack_seen", imem_ack, 1);
        step(0, 1, 1, 16'h0200);
        run_until_req(1, 20);
        chk("coincide_req_addr", new_req_addr, 16'h0200);
        run_until_ins(1, 30);
        chk("coincide_ins_pc", ins_pc, 16'h0200);
        chk("coincide_ins", ins, 16'h3000);

        // Randomized traffic against the stream model
        rand_delay = 1;
        ic0 = ins_cnt;
        for (int c = 0; c < 3000; c++) begin
            rd = ($urandom_range(0, 39) == 0);
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            step(0, $urandom_range(0, 9) < 7, rd, a);
        end
        chk("random_progress", (ins_cnt - ic0) > 100, 1);

        // Reset mid-request; the late ack lands while the FSM is idle
        rand_delay = 0; ack_delay = 3;
        repeat (4) step(0, 1, 0, 16'h0);
        run_until_req(1, 20);
        step(1, 1, 0, 16'h0);
        chk("rst2_imem_req", imem_req, 0);
        chk("rst2_imem_addr", imem_addr, 16'h0000);
        chk("rst2_ins", ins, 0);
        chk("rst2_ext", ext, 0);
        chk("rst2_ins_pc", ins_pc, 0);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        run_until_ins(1, 30);
        chk("post_rst_ins_pc", ins_pc, 16'h0000);
        chk("post_rst_ins", ins, 16'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
